router_pkt_receiver: RTL and testbench
======================================

Name: router_pkt_receiver

Overview:
Downstream consumer for one router output port. It drains the port's FIFO through the vld_out/read_enb/data_out interface and re-frames the packet (header, payload, parity) onto a valid/ready byte stream with sop/eop. It checks the header address against the port ID, checks the parity, and detects stalled or aborted packets. One instance is placed per output port.

Parameters:
PORT_ID, 0, 2-bit port address expected in header bits [1:0]
TIMEOUT, 32, consecutive cycles with vld_out low mid-packet before the packet is aborted (legal range 2..255)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
vld_out  in  1  port FIFO not-empty; reflects all reads issued in earlier cycles
data_out  in  8  FIFO read data; valid the cycle after read_enb
read_enb  out  1  FIFO read strobe
m_data  out  8  output byte
m_valid  out  1  output byte valid
m_ready  in  1  downstream accept
m_sop  out  1  qualifies m_data as header byte
m_eop  out  1  qualifies m_data as parity byte
pkt_done  out  1  1-cycle pulse when the parity byte is captured
parity_err  out  1  valid with pkt_done; received parity != computed parity
addr_err  out  1  sticky per packet; header[1:0] != PORT_ID; cleared at next header
pkt_abort  out  1  1-cycle pulse on timeout
pkt_len  out  6  header[7:2] of current/last packet
rx_busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = IDLE.
  - Skid buffer empty, in-flight flag 0, parity accumulator 0, counters 0.
- Read issue:
  - read_enb = vld_out && (state != ABORT) && (occupancy + inflight < 2) && bytes_outstanding > 0.
  - Byte captured at t+1 into the 2-entry skid buffer (router_rx_skid).
  - Back-to-back reads are legal.
  - Never issue more reads than header + len + parity bytes; in IDLE exactly one read (the header).
- FSM states:
  - IDLE: vld_out=1 → issue header read → HDR.
  - HDR: on capture, latch pkt_len = byte[7:2], addr_err = (byte[1:0] != PORT_ID), parity_acc = byte, remaining = len. If len=0 → PARITY, else → PAYLOAD.
  - PAYLOAD: each captured byte does parity_acc ^= byte and remaining--. At remaining==0 → PARITY.
  - PARITY: on capture, pkt_done pulses and parity_err = (byte != parity_acc) → IDLE.
  - ABORT: flush the skid buffer and in-flight flag, pulse pkt_abort → IDLE.
- Output side:
  - m_valid = skid buffer not empty.
  - Transfer occurs when m_valid && m_ready.
  - m_sop is set on the header entry; m_eop on the parity entry.
  - m_data, m_sop and m_eop are held stable while m_valid && !m_ready.
- Latency: vld_out high to m_valid for the header is 2 cycles (read, capture) with an empty buffer.
- Timeout:
  - In HDR/PAYLOAD/PARITY with an outstanding byte and vld_out low, the stall counter increments; any capture clears it.
  - Counter reaching TIMEOUT → ABORT. No m_eop is sent for an aborted packet.
  - Downstream stalling with vld_out high is not a timeout; the FIFO's own soft-reset handles that case and then drops vld_out, which triggers the timeout.
- Simultaneous events:
  - Capture and output transfer in the same cycle keep occupancy unchanged.
  - A timeout and a capture in the same cycle: the capture wins and the stall counter clears.
- Next packet: a new header read may be issued the cycle after the parity capture, even while the previous packet's bytes still drain from the skid buffer.
- Reset mid-packet: the next edge returns to reset values; read_enb is low in the cycle after reset.

Optional Feature:
- Macro: ROUTER_RX_STATS_EN.
- When defined, these output ports are added:
  - pkt_count[15:0]: increments on each pkt_done.
  - err_count[15:0]: increments on pkt_done with parity_err or addr_err.
  - abort_count[7:0]: increments on each pkt_abort.
  - All counters saturate and are cleared by reset.
- When undefined, these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package router_rx_pkg holds:
  - rx_state_t enum (IDLE, HDR, PAYLOAD, PARITY, ABORT)
  - ADDR_MSB/LSB = 1/0, LEN_MSB/LSB = 7/2
  - skid entry typedef {data, sop, eop}
- Sub-module router_rx_skid: 2-entry buffer with push/pop, occupancy and flush.

Test Plan:
- PORT_ID=1; FIFO holds 0x0D, 0x11, 0x22, 0x33, 0x0D; m_ready=1 → 5 bytes out; sop on 0x0D, eop on final 0x0D; pkt_done with parity_err=0, addr_err=0, pkt_len=3.
- Same packet with parity byte 0x0C → pkt_done, parity_err=1; all 5 bytes forwarded.
- Header 0x02 (len 0, addr 2), PORT_ID=1, parity 0x02 → 2 bytes out, addr_err=1, parity_err=0.
- m_ready low for 10 cycles mid-payload → read_enb low once occupancy = 2; no byte lost or duplicated; m_data stable throughout.
- Header 0x29 (len 10), vld_out drops after 4 payload bytes for TIMEOUT=32 cycles → pkt_abort pulse, no m_eop, rx_busy=0, next header received cleanly.
- reset asserted during PAYLOAD → next cycle all outputs 0 and state IDLE; with ROUTER_RX_STATS_EN, counters read 0.

Source files
------------

// File: rtl/router_rx_pkg.sv
// Shared types for the router output-port receiver: FSM states, header field positions, skid entry.
package router_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PARITY,
    ABORT
  } rx_state_t;

  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } skid_entry_t;

endpackage

// File: rtl/router_rx_skid.sv
// Two-entry skid buffer between FIFO capture and the output stream; head is held until popped.
// Flush empties it in one cycle; pushing into a full buffer without a pop is prevented by the caller.
module router_rx_skid
  import router_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  skid_entry_t push_dat_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output skid_entry_t head_o,
  output logic [1:0]  occ_o
);

  skid_entry_t e0_q, e1_q;
  logic [1:0]  occ_q;
  logic        pop_ok;

  assign pop_ok = pop_i && (occ_q != 2'd0);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      case ({push_i, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) e0_q <= push_dat_i;
          else               e1_q <= push_dat_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new byte lands behind whatever remains
          if (occ_q == 2'd1) begin
            e0_q <= push_dat_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o = e0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/router_pkt_receiver.sv
// Drains one router output-port FIFO and re-frames header/payload/parity as a sop/eop byte stream.
// Header reaches m_valid 2 cycles after vld_out; ROUTER_RX_STATS_EN adds saturating packet/error/abort counters.
module router_pkt_receiver
  import router_rx_pkg::*;
#(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int          TIMEOUT = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sop,
  output logic        m_eop,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        addr_err,
  output logic        pkt_abort,
  output logic [5:0]  pkt_len,
  output logic        rx_busy
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
  output logic [7:0]  abort_count
`endif
);

  rx_state_t   state_q;
  logic        inflight_q;
  logic [6:0]  rd_left_q;
  logic [5:0]  remain_q;
  logic [7:0]  par_q;
  logic [7:0]  stall_q;
  logic        pkt_done_q, parity_err_q, addr_err_q, pkt_abort_q;
  logic [5:0]  pkt_len_q;

  logic        cap, pop, outstanding, room, stall_inc, timeout;
  logic [1:0]  occ;
  logic [5:0]  hdr_len;
  skid_entry_t head, push_dat;

  // A read always lands the next cycle, so the in-flight flag doubles as the capture strobe.
  assign cap         = inflight_q;
  assign hdr_len     = data_out[LEN_MSB:LEN_LSB];
  assign outstanding = (state_q == IDLE) ? 1'b1 : (rd_left_q != 7'd0);
  assign room        = (occ + {1'b0, inflight_q}) < 2'd2;
  assign read_enb    = !reset && vld_out && (state_q != ABORT) && room && outstanding;
  assign pop         = m_valid && m_ready;
  assign stall_inc   = (state_q == HDR || state_q == PAYLOAD || state_q == PARITY) &&
                       (rd_left_q != 7'd0) && !vld_out && !cap;
  assign timeout     = stall_inc && (stall_q == 8'(TIMEOUT - 1));

  always_comb begin
    push_dat      = '0;
    push_dat.data = data_out;
    push_dat.sop  = (state_q == HDR);
    push_dat.eop  = (state_q == PARITY);
  end

  router_rx_skid u_skid (
    .clk        (clock),
    .reset      (reset),
    .push_i     (cap),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (state_q == ABORT),
    .head_o     (head),
    .occ_o      (occ)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      inflight_q   <= 1'b0;
      rd_left_q    <= 7'd0;
      remain_q     <= 6'd0;
      par_q        <= 8'd0;
      stall_q      <= 8'd0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_abort_q  <= 1'b0;
      pkt_len_q    <= 6'd0;
    end else begin
      inflight_q  <= read_enb;
      pkt_done_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
      if (read_enb && state_q != IDLE) rd_left_q <= rd_left_q - 7'd1;
      if (cap)            stall_q <= 8'd0;
      else if (stall_inc) stall_q <= stall_q + 8'd1;

      case (state_q)
        IDLE: begin
          stall_q <= 8'd0;
          if (read_enb) state_q <= HDR;
        end
        HDR: if (cap) begin
          pkt_len_q  <= hdr_len;
          addr_err_q <= (data_out[ADDR_MSB:ADDR_LSB] != PORT_ID);
          par_q      <= data_out;
          remain_q   <= hdr_len;
          rd_left_q  <= {1'b0, hdr_len} + 7'd1;
          state_q    <= (hdr_len == 6'd0) ? PARITY : PAYLOAD;
        end
        PAYLOAD: if (cap) begin
          par_q    <= par_q ^ data_out;
          remain_q <= remain_q - 6'd1;
          if (remain_q == 6'd1) state_q <= PARITY;
        end
        PARITY: if (cap) begin
          pkt_done_q   <= 1'b1;
          parity_err_q <= (data_out != par_q);
          state_q      <= IDLE;
        end
        ABORT: begin
          rd_left_q <= 7'd0;
          stall_q   <= 8'd0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (timeout) begin
        state_q     <= ABORT;
        pkt_abort_q <= 1'b1;
      end
    end
  end

  assign m_valid    = (occ != 2'd0);
  assign m_data     = head.data;
  assign m_sop      = m_valid && head.sop;
  assign m_eop      = m_valid && head.eop;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign pkt_abort  = pkt_abort_q;
  assign pkt_len    = pkt_len_q;
  assign rx_busy    = (state_q != IDLE);

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_count_q, err_count_q;
  logic [7:0]  abort_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_q   <= 16'd0;
      err_count_q   <= 16'd0;
      abort_count_q <= 8'd0;
    end else begin
      if (pkt_done_q && pkt_count_q != 16'hFFFF) pkt_count_q <= pkt_count_q + 16'd1;
      if (pkt_done_q && (parity_err_q || addr_err_q) && err_count_q != 16'hFFFF)
        err_count_q <= err_count_q + 16'd1;
      if (pkt_abort_q && abort_count_q != 8'hFF) abort_count_q <= abort_count_q + 8'd1;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign err_count   = err_count_q;
  assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_router_pkt_receiver.sv
// Bench for router_pkt_receiver: array-backed port FIFO, packet-level reference model, directed and random packets.
module tb_router_pkt_receiver;

  localparam logic [1:0] PID = 2'd1;
  localparam int         TMO = 32;

  logic       clock = 1'b0;
  logic       reset, vld_out, read_enb, m_valid, m_ready, m_sop, m_eop;
  logic       pkt_done, parity_err, addr_err, pkt_abort, rx_busy;
  logic [7:0] data_out, m_data;
  logic [5:0] pkt_len;
`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_count, err_count;
  logic [7:0]  abort_count;
`endif

  always #5 clock = ~clock;

  router_pkt_receiver #(.PORT_ID(PID), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_abort  (pkt_abort),
    .pkt_len    (pkt_len),
    .rx_busy    (rx_busy)
`ifdef ROUTER_RX_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .err_count  (err_count),
    .abort_count(abort_count)
`endif
  );

  // Port FIFO: bench appends at push_cnt, DUT reads advance pop_cnt on the clock edge.
  logic [7:0] mem [0:4095];
  int   push_cnt = 0;
  int   pop_cnt  = 0;
  logic hold     = 1'b0;

  assign vld_out = !hold && (push_cnt != pop_cnt);

  always @(posedge clock) begin
    if (read_enb) begin
      data_out <= mem[pop_cnt[11:0]];
      pop_cnt  <= pop_cnt + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: expected beats {sop,eop,data} and results {perr,aerr,len}.
  logic [9:0] exp_q[$];
  logic [7:0] res_q[$];
  logic [7:0] pl_q[$];
  int pkt_exp = 0, err_exp = 0, abort_exp = 0, aborts_seen = 0;

  task automatic put_byte(input logic [7:0] b);
    mem[push_cnt[11:0]] = b;
    push_cnt = push_cnt + 1;
  endtask

  // keep < 0: full packet; otherwise only header + keep payload bytes reach the FIFO.
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] par_flip, input int keep);
    logic [7:0] par;
    logic       aerr;
    int         n;
    par  = hdr;
    n    = int'(hdr[7:2]);
    aerr = (hdr[1:0] != PID);
    put_byte(hdr);
    exp_q.push_back({2'b10, hdr});
    for (int i = 0; i < n; i++) begin
      par = par ^ pl_q[i];
      if (keep < 0 || i < keep) begin
        put_byte(pl_q[i]);
        exp_q.push_back({2'b00, pl_q[i]});
      end
    end
    if (keep < 0) begin
      put_byte(par ^ par_flip);
      exp_q.push_back({2'b01, par ^ par_flip});
      res_q.push_back({par_flip != 8'd0, aerr, hdr[7:2]});
      pkt_exp++;
      if (par_flip != 8'd0 || aerr) err_exp++;
    end else begin
      abort_exp++;
    end
  endtask

  task automatic rand_pl(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  task automatic cyc(input int n, input int rdy_pct);
    repeat (n) begin
      @(negedge clock);
      m_ready = ($urandom_range(99) < rdy_pct);
    end
  endtask

  task automatic drain(input string tag, input int budget, input int rdy_pct);
    int i;
    i = 0;
    while (i < budget && !(exp_q.size() == 0 && res_q.size() == 0 && !rx_busy &&
                           push_cnt == pop_cnt)) begin
      cyc(1, rdy_pct);
      i++;
    end
    check(tag, i < budget, 1);
    @(negedge clock);
    m_ready = 1'b1;
    #1;
  endtask

  // Output monitor: beat order, stability under backpressure, packet results.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat;
  always @(negedge clock) begin
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {m_valid, m_sop, m_eop, m_data}, {1'b1, prev_beat});
      if (m_valid && m_ready)
        check("beat", {m_sop, m_eop, m_data}, exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_sop, m_eop, m_data};
      if (pkt_done)
        check("pkt_result", {parity_err, addr_err, pkt_len}, res_q.size() != 0 ? 32'(res_q.pop_front()) : 32'hDEAD_BEEF);
      if (pkt_abort) aborts_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    reset   = 1'b1;
    m_ready = 1'b1;
    cyc(3, 100);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("rst_read_enb", read_enb, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_sop_eop", {m_sop, m_eop}, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flags", {pkt_done, parity_err, addr_err, pkt_abort}, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_rx_busy", rx_busy, 0);

    // Good packet, PORT_ID match, with header latency check.
    pl_q = '{8'h11, 8'h22, 8'h33};
    push_pkt(8'h0D, 8'h00, -1);
    #1;
    check("t1_read_issue", read_enb, 1);
    @(negedge clock); #1;
    check("t1_latency_early", m_valid, 0);
    @(negedge clock); #1;
    check("t1_latency_hdr", {m_valid, m_sop, m_data}, {1'b1, 1'b1, 8'h0D});
    drain("t1_drain", 200, 100);
    check("t1_pkt_len", pkt_len, 3);
    check("t1_errs", {parity_err, addr_err}, 0);

    // Same packet, corrupted parity byte 0x0C.
    push_pkt(8'h0D, 8'h01, -1);
    drain("t2_drain", 200, 100);
    check("t2_parity_err", parity_err, 1);

    // Zero-length packet addressed to port 2.
    pl_q.delete();
    push_pkt(8'h02, 8'h00, -1);
    drain("t3_drain", 200, 100);
    check("t3_addr_err", addr_err, 1);
    check("t3_parity_err", parity_err, 0);
    check("t3_pkt_len", pkt_len, 0);

    // Downstream stall mid-payload.
    rand_pl(20);
    push_pkt({6'd20, 2'd1}, 8'h00, -1);
    cyc(8, 100);
    for (int s = 1; s <= 10; s++) begin
      cyc(1, 0);
      #1;
      if (s >= 4) check("t4_read_blocked", read_enb, 0);
    end
    drain("t4_drain", 300, 100);

    // Truncated packet: vld_out goes away after 4 payload bytes.
    rand_pl(10);
    push_pkt(8'h29, 8'h00, 4);
    i = 0;
    while (i < 300 && aborts_seen == 0) begin
      cyc(1, 100);
      i++;
    end
    check("t5_abort_seen", aborts_seen, 1);
    check("t5_abort_not_early", i >= TMO, 1);
    cyc(2, 100);
    #1;
    check("t5_rx_busy", rx_busy, 0);
    check("t5_beats_left", exp_q.size(), 0);
    rand_pl(5);
    push_pkt({6'd5, 2'd1}, 8'h00, -1);
    drain("t5_next_drain", 200, 100);
    check("t5_next_len", pkt_len, 5);

    // Random packets queued back-to-back with random backpressure.
    for (int p = 0; p < 25; p++) begin
      int n;
      n = $urandom_range(0, 40);
      rand_pl(n);
      push_pkt({6'(n), 2'($urandom_range(0, 3))},
               ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, -1);
    end
    drain("rand_drain", 20000, 70);
    check("rand_aborts", aborts_seen, abort_exp);

`ifdef ROUTER_RX_STATS_EN
    cyc(2, 100);
    #1;
    check("stats_pkt_count", pkt_count, pkt_exp);
    check("stats_err_count", err_count, err_exp);
    check("stats_abort_count", abort_count, abort_exp);
`endif

    // Reset in the middle of a payload.
    rand_pl(20);
    push_pkt({6'd20, 2'd1}, 8'h00, -1);
    cyc(10, 100);
    reset = 1'b1;
    exp_q.delete();
    res_q.delete();
    @(negedge clock); #1;
    check("mid_rst_rx_busy", rx_busy, 0);
    check("mid_rst_m_valid", {m_valid, m_sop, m_eop, m_data}, 0);
    check("mid_rst_read_enb", read_enb, 0);
    check("mid_rst_status", {pkt_done, parity_err, addr_err, pkt_abort, pkt_len}, 0);
`ifdef ROUTER_RX_STATS_EN
    check("mid_rst_counters", {pkt_count, err_count, abort_count}, 0);
`endif
    hold  = 1'b1;
    reset = 1'b0;
    @(negedge clock); #1;
    check("post_rst_read_enb", read_enb, 0);
    check("post_rst_rx_busy", rx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
